bus_dma_engine: RTL and testbench

//  Parametrised bus-master DMA moving word blocks between a local ping-pong buffer and the shared bus.

---
 rtl/bus_dma_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_bus_dma_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma_engine.sv
// Bus-master DMA engine: moves word blocks between the local ping-pong buffer
// and the shared bus. Each block is split into bursts limited by the remaining
// length, the programmed burst size, MAX_BURST and a BOUNDARY-aligned window.
module bus_dma_engine #(
  parameter int BUF_AW    = 9,
  parameter int MAX_BURST = 256,
  parameter int BOUNDARY  = 1024
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              cmd_start,
  input  logic              cmd_read_n_write,
  input  logic              cmd_fixed_addr,
  input  logic [31:0]       cmd_address,
  input  logic [3:0]        cmd_byte_enable,
  input  logic [7:0]        cmd_burst_size,
  input  logic [BUF_AW:0]   cmd_words,
  input  logic              cmd_abort,
  output logic              status_busy,
  output logic              status_done,
  output logic              status_error,
  output logic              status_aborted,
  output logic [BUF_AW:0]   status_words_done,
  output logic [BUF_AW-1:0] buf_address,
  output logic [31:0]       buf_write_data,
  output logic              buf_write_enable,
  input  logic [31:0]       buf_read_data,
  input  logic [31:0]       address_dataIN,
  input  logic              end_transactionIN,
  input  logic              data_validIN,
  input  logic              busyIN,
  input  logic              bus_errorIN,
  output logic [31:0]       address_dataOUT,
  output logic [3:0]        byte_enableOUT,
  output logic [7:0]        burst_sizeOUT,
  output logic              read_n_writeOUT,
  output logic              begin_transactionOUT,
  output logic              end_transactionOUT,
  output logic              data_validOUT,
  output logic              busyOUT,
  output logic              requestTransaction,
  input  logic              transactionGranted
);

  localparam int CW = BUF_AW + 1;
  localparam int BW = $clog2(BOUNDARY);
  localparam int W0 = (CW > BW) ? CW : BW;
  // Width wide enough for every burst-length candidate (256 needs 9 bits).
  localparam int W  = (W0 > 9) ? W0 : 9;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_REQ, S_SETUP, S_BEGIN, S_READ, S_WAIT_END, S_WRITE, S_ENDW, S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic              rnw_reg, rnw_next, fixed_reg, fixed_next;
  logic [3:0]        be_reg, be_next;
  logic [7:0]        bsize_reg, bsize_next;
  logic [31:0]       addr_reg, addr_next;
  logic [BUF_AW-1:0] ptr_reg, ptr_next;
  logic [CW-1:0]     remaining_reg, remaining_next, words_done_reg, words_done_next;
  logic [W-1:0]      n_reg, n_next, beats_left_reg, beats_left_next, n_calc, room, bs1;
  logic              done_reg, done_next, error_reg, error_next, aborted_reg, aborted_next;
  logic              dv_reg, end_reg, err_reg;
  logic [31:0]       rdata_reg;
  logic              beat, read_beat, last_read, stop_req;

  // Burst length for the next burst: min of remaining, requested, cap and window room.
  always_comb begin
    bs1    = W'(bsize_reg) + W'(1);
    room   = W'(BOUNDARY / 4) - W'((addr_reg & 32'(BOUNDARY - 1)) >> 2);
    n_calc = W'(remaining_reg);
    if (bs1 < n_calc) n_calc = bs1;
    if (W'(MAX_BURST) < n_calc) n_calc = W'(MAX_BURST);
    if (!fixed_reg && room < n_calc) n_calc = room;
  end

  // Next-state and datapath update for the transfer sequencer.
  always_comb begin
    state_next       = state_reg;
    rnw_next         = rnw_reg;
    fixed_next       = fixed_reg;
    be_next          = be_reg;
    bsize_next       = bsize_reg;
    addr_next        = addr_reg;
    ptr_next         = ptr_reg;
    remaining_next   = remaining_reg;
    words_done_next  = words_done_reg;
    n_next           = n_reg;
    beats_left_next  = beats_left_reg;
    done_next        = done_reg;
    error_next       = error_reg;
    aborted_next     = aborted_reg;
    buf_write_enable = 1'b0;
    beat             = 1'b0;
    read_beat        = dv_reg && (beats_left_reg != '0);
    last_read        = read_beat ? (remaining_reg == CW'(1)) : (remaining_reg == '0);
    stop_req         = aborted_reg || cmd_abort;
    if (cmd_abort && state_reg != S_IDLE) aborted_next = 1'b1;
    case (state_reg)
      S_IDLE: if (cmd_start) begin
        rnw_next        = cmd_read_n_write;
        fixed_next      = cmd_fixed_addr;
        be_next         = cmd_byte_enable;
        bsize_next      = cmd_burst_size;
        addr_next       = {cmd_address[31:2], 2'b00};
        remaining_next  = cmd_words;
        ptr_next        = '0;
        words_done_next = '0;
        done_next       = 1'b0;
        error_next      = 1'b0;
        aborted_next    = 1'b0;
        state_next      = S_START;
      end
      S_START: state_next = (remaining_reg == '0) ? S_DONE : S_REQ;
      S_REQ: begin
        if (stop_req) state_next = S_DONE;
        else if (transactionGranted) state_next = S_SETUP;
      end
      S_SETUP: begin
        n_next          = n_calc;
        beats_left_next = n_calc;
        state_next      = S_BEGIN;
      end
      S_BEGIN: state_next = rnw_reg ? S_READ : S_WRITE;
      S_READ: begin
        if (err_reg) begin
          if (end_reg) begin
            error_next = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_WAIT_END;
          end
        end else begin
          if (read_beat) begin
            beat             = 1'b1;
            buf_write_enable = 1'b1;
          end
          if (end_reg) state_next = (last_read || stop_req) ? S_DONE : S_REQ;
        end
      end
      S_WAIT_END: if (end_reg) begin
        error_next = 1'b1;
        state_next = S_DONE;
      end
      S_WRITE: begin
        if (bus_errorIN) begin
          error_next = 1'b1;
          state_next = S_ENDW;
        end else if (!busyIN) begin
          beat = 1'b1;
          if (beats_left_reg == W'(1)) state_next = S_ENDW;
        end
      end
      S_ENDW: state_next = (error_reg || remaining_reg == '0 || stop_req) ? S_DONE : S_REQ;
      S_DONE: begin
        done_next  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // One accepted beat advances every pointer and counter together.
    if (beat) begin
      ptr_next        = ptr_reg + BUF_AW'(1);
      remaining_next  = remaining_reg - CW'(1);
      words_done_next = words_done_reg + CW'(1);
      beats_left_next = beats_left_reg - W'(1);
      if (!fixed_reg) addr_next = addr_reg + 32'd4;
    end
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_reg      <= S_IDLE;
      rnw_reg        <= 1'b0;
      fixed_reg      <= 1'b0;
      be_reg         <= '0;
      bsize_reg      <= '0;
      addr_reg       <= '0;
      ptr_reg        <= '0;
      remaining_reg  <= '0;
      words_done_reg <= '0;
      n_reg          <= '0;
      beats_left_reg <= '0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
      aborted_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rnw_reg        <= rnw_next;
      fixed_reg      <= fixed_next;
      be_reg         <= be_next;
      bsize_reg      <= bsize_next;
      addr_reg       <= addr_next;
      ptr_reg        <= ptr_next;
      remaining_reg  <= remaining_next;
      words_done_reg <= words_done_next;
      n_reg          <= n_next;
      beats_left_reg <= beats_left_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
      aborted_reg    <= aborted_next;
    end
  end

  // Read-side bus inputs pass through one register stage.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      dv_reg    <= 1'b0;
      end_reg   <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      dv_reg    <= data_validIN;
      end_reg   <= end_transactionIN;
      err_reg   <= bus_errorIN;
      rdata_reg <= address_dataIN;
    end
  end

  // Writes look one beat ahead so the 1-cycle buffer latency is hidden.
  assign buf_address          = rnw_reg ? ptr_reg : ptr_next;
  assign buf_write_data       = buf_write_enable ? rdata_reg : 32'd0;
  assign status_busy          = (state_reg != S_IDLE);
  assign status_done          = done_reg;
  assign status_error         = error_reg;
  assign status_aborted       = aborted_reg;
  assign status_words_done    = words_done_reg;
  assign requestTransaction   = (state_reg == S_REQ);
  assign begin_transactionOUT = (state_reg == S_BEGIN);
  assign address_dataOUT      = (state_reg == S_BEGIN) ? addr_reg :
                                (state_reg == S_WRITE) ? buf_read_data : 32'd0;
  assign byte_enableOUT       = (state_reg == S_BEGIN) ? be_reg : 4'd0;
  assign burst_sizeOUT        = (state_reg == S_BEGIN) ? 8'(n_reg - W'(1)) : 8'd0;
  assign read_n_writeOUT      = (state_reg == S_BEGIN) && rnw_reg;
  assign data_validOUT        = (state_reg == S_WRITE);
  assign end_transactionOUT   = (state_reg == S_ENDW);
  assign busyOUT              = 1'b0;

endmodule

// File: tb/tb_bus_dma_engine.sv
// Self-checking bench for bus_dma_engine: acts as arbiter, bus slave and
// buffer RAM, and checks bursts, data and status against a burst-split model.
module tb_bus_dma_engine;
  localparam int AW    = 9;
  localparam int MAXB  = 16;
  localparam int BOUND = 1024;

  logic clock = 1'b0, n_reset = 1'b0;
  logic cmd_start = 0, cmd_read_n_write = 0, cmd_fixed_addr = 0, cmd_abort = 0;
  logic [31:0] cmd_address = 0;
  logic [3:0]  cmd_byte_enable = 0;
  logic [7:0]  cmd_burst_size = 0;
  logic [AW:0] cmd_words = 0;
  logic status_busy, status_done, status_error, status_aborted;
  logic [AW:0] status_words_done;
  logic [AW-1:0] buf_address;
  logic [31:0] buf_write_data, buf_read_data;
  logic buf_write_enable;
  logic [31:0] address_dataIN = 0, address_dataOUT;
  logic end_transactionIN = 0, data_validIN = 0, busyIN = 0, bus_errorIN = 0;
  logic [3:0] byte_enableOUT;
  logic [7:0] burst_sizeOUT;
  logic read_n_writeOUT, begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT;
  logic requestTransaction, transactionGranted = 0;

  logic [31:0] buf_mem [0:511];
  logic [31:0] shadow  [0:511];
  logic        pl_en = 0;
  logic [8:0]  pl_addr = 0;
  logic [31:0] pl_data = 0;
  logic [31:0] exp_addr[$];
  int          exp_len[$];
  int          n_cmp = 0, n_err = 0;

  always #5 clock = ~clock;

  // Buffer RAM with registered read; the bench preloads it through pl_*.
  always @(posedge clock) begin
    buf_read_data <= buf_mem[buf_address];
    if (buf_write_enable) buf_mem[buf_address] <= buf_write_data;
    else if (pl_en) buf_mem[pl_addr] <= pl_data;
  end

  bus_dma_engine #(.BUF_AW(AW), .MAX_BURST(MAXB), .BOUNDARY(BOUND)) dut (
    .clock(clock), .n_reset(n_reset), .cmd_start(cmd_start),
    .cmd_read_n_write(cmd_read_n_write), .cmd_fixed_addr(cmd_fixed_addr),
    .cmd_address(cmd_address), .cmd_byte_enable(cmd_byte_enable),
    .cmd_burst_size(cmd_burst_size), .cmd_words(cmd_words), .cmd_abort(cmd_abort),
    .status_busy(status_busy), .status_done(status_done), .status_error(status_error),
    .status_aborted(status_aborted), .status_words_done(status_words_done),
    .buf_address(buf_address), .buf_write_data(buf_write_data),
    .buf_write_enable(buf_write_enable), .buf_read_data(buf_read_data),
    .address_dataIN(address_dataIN), .end_transactionIN(end_transactionIN),
    .data_validIN(data_validIN), .busyIN(busyIN), .bus_errorIN(bus_errorIN),
    .address_dataOUT(address_dataOUT), .byte_enableOUT(byte_enableOUT),
    .burst_sizeOUT(burst_sizeOUT), .read_n_writeOUT(read_n_writeOUT),
    .begin_transactionOUT(begin_transactionOUT), .end_transactionOUT(end_transactionOUT),
    .data_validOUT(data_validOUT), .busyOUT(busyOUT),
    .requestTransaction(requestTransaction), .transactionGranted(transactionGranted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Burst list derived from the splitting rules; returns the expected word count.
  task automatic build_model(input bit fixed, input logic [31:0] addr, input int bs,
                             input int words, input int err_beat, input int abort_burst,
                             output int exp_words);
    logic [31:0] a;
    int rem, n, tot, room;
    exp_addr.delete(); exp_len.delete();
    a = addr & 32'hFFFF_FFFC; rem = words; tot = 0;
    while (rem > 0) begin
      n = rem;
      if (bs + 1 < n) n = bs + 1;
      if (MAXB < n) n = MAXB;
      room = (BOUND - int'(a % BOUND)) / 4;
      if (!fixed && room < n) n = room;
      exp_addr.push_back(a); exp_len.push_back(n);
      rem -= n; tot += n;
      if (!fixed) a = a + 32'(4 * n);
      if (err_beat >= 0 && err_beat < tot) break;
      if (abort_burst >= 0 && exp_len.size() == abort_burst + 1) break;
    end
    exp_words = (err_beat >= 0) ? err_beat : tot;
  endtask

  // One command: drive it, then act as arbiter and slave cycle by cycle.
  task automatic run_xfer(input bit rnw, input bit fixed, input logic [31:0] addr, input int bs,
                          input int words, input int err_beat, input int busy_mode,
                          input int abort_burst);
    int exp_words, burst_i, sent, slave_n, accepted, endw_cnt, req_cycles, held, err_wait;
    int busy_cycles;
    bit slave_on, err_mode, finished;
    logic [31:0] rq[$];
    logic [3:0] be;
    build_model(fixed, addr, bs, words, err_beat, abort_burst, exp_words);
    burst_i = 0; sent = 0; slave_n = 0; accepted = 0; endw_cnt = 0; req_cycles = 0;
    held = 0; err_wait = 0; busy_cycles = 0; slave_on = 0; err_mode = 0; finished = 0;
    be = 4'($urandom_range(1, 15));
    @(negedge clock);
    cmd_read_n_write = rnw; cmd_fixed_addr = fixed; cmd_address = addr;
    cmd_byte_enable = be; cmd_burst_size = 8'(bs); cmd_words = 10'(words); cmd_start = 1;
    @(negedge clock);
    cmd_start = 0; cmd_address = $urandom; cmd_burst_size = 8'($urandom); cmd_words = 10'($urandom);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      data_validIN = 0; end_transactionIN = 0; bus_errorIN = 0; busyIN = 0;
      transactionGranted = 0; address_dataIN = 0;
      if (!status_busy) begin finished = 1; break; end
      busy_cycles++;
      if (requestTransaction) begin
        req_cycles++;
        transactionGranted = ($urandom_range(0, 2) != 0);
      end
      if (begin_transactionOUT) begin
        if (burst_i < exp_len.size()) begin
          chk("burst_addr", address_dataOUT, exp_addr[burst_i]);
          chk("burst_size", {24'd0, burst_sizeOUT}, exp_len[burst_i] - 1);
          slave_n = exp_len[burst_i];
        end else begin
          chk("extra_burst", burst_i, exp_len.size());
          slave_n = int'(burst_sizeOUT) + 1;
        end
        chk("burst_rnw", {31'd0, read_n_writeOUT}, {31'd0, rnw});
        chk("burst_be", {28'd0, byte_enableOUT}, {28'd0, be});
        if (abort_burst >= 0 && burst_i == abort_burst) cmd_abort = 1;
        burst_i++; slave_on = rnw; sent = 0;
      end
      if (data_validOUT) begin
        chk("write_data", address_dataOUT, shadow[accepted % 512]);
        if (busy_mode == 1) busyIN = ($urandom_range(0, 3) == 0);
        if (busy_mode == 2 && accepted == 2 && held < 3) begin busyIN = 1; held++; end
        if (!busyIN) accepted++;
      end
      if (end_transactionOUT) endw_cnt++;
      if (slave_on) begin
        if (err_mode) begin
          if (err_wait == 0) begin end_transactionIN = 1; slave_on = 0; end
          else err_wait--;
        end else if (sent < slave_n) begin
          if ($urandom_range(0, 3) != 0) begin
            if (rq.size() == err_beat) begin
              bus_errorIN = 1; err_mode = 1; err_wait = 2;
            end else begin
              address_dataIN = $urandom; data_validIN = 1;
              rq.push_back(address_dataIN); sent++;
            end
          end
        end else begin
          end_transactionIN = 1; slave_on = 0;
        end
      end
      @(negedge clock);
    end
    cmd_abort = 0;
    chk("finished", {31'd0, finished}, 32'd1);
    chk("done", {31'd0, status_done}, 32'd1);
    chk("error", {31'd0, status_error}, (err_beat >= 0) ? 32'd1 : 32'd0);
    chk("aborted", {31'd0, status_aborted}, (abort_burst >= 0) ? 32'd1 : 32'd0);
    chk("words_done", {22'd0, status_words_done}, exp_words);
    chk("burst_count", burst_i, exp_len.size());
    if (words == 0) begin
      chk("zero_req_cycles", req_cycles, 0);
      chk("zero_busy_cycles", busy_cycles, 2);
    end
    if (!rnw) begin
      chk("write_beats", accepted, exp_words);
      chk("end_pulses", endw_cnt, exp_len.size());
    end else begin
      foreach (rq[i]) begin
        chk("buf_word", buf_mem[i], rq[i]);
        shadow[i] = rq[i];
      end
    end
    $display("xfer rnw=%0d fixed=%0d addr=0x%08h bs=%0d words=%0d bursts=%0d words_done=%0d err=%0d abort=%0d",
             rnw, fixed, addr, bs, words, burst_i, status_words_done, status_error, status_aborted);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      @(negedge clock);
      pl_en = 1; pl_addr = 9'(i); pl_data = $urandom; shadow[i] = pl_data;
    end
    @(negedge clock);
    pl_en = 0;
    chk("rst_busy", {31'd0, status_busy}, 32'd0);
    chk("rst_done", {31'd0, status_done}, 32'd0);
    chk("rst_error", {31'd0, status_error}, 32'd0);
    chk("rst_aborted", {31'd0, status_aborted}, 32'd0);
    chk("rst_words", {22'd0, status_words_done}, 32'd0);
    chk("rst_req", {31'd0, requestTransaction}, 32'd0);
    chk("rst_begin", {31'd0, begin_transactionOUT}, 32'd0);
    chk("rst_valid", {31'd0, data_validOUT}, 32'd0);
    chk("rst_addr_out", address_dataOUT, 32'd0);
    chk("rst_buf_we", {31'd0, buf_write_enable}, 32'd0);
    n_reset = 1;
    @(negedge clock);
    run_xfer(1, 0, 32'h100, 7, 5, -1, 0, -1);     // single read burst of 5
    run_xfer(0, 0, 32'h3F0, 31, 20, -1, 0, -1);   // write split at 1 KiB boundary
    run_xfer(0, 0, 32'h80, 3, 4, -1, 2, -1);      // write stalled 3 cycles mid-burst
    run_xfer(1, 0, 32'h200, 7, 8, 2, 0, -1);      // read error on beat 2
    run_xfer(1, 0, 32'h0, 15, 48, -1, 0, 0);      // abort during first of 3 bursts
    run_xfer(0, 0, 32'h40, 3, 0, -1, 0, -1);      // zero-length command
    run_xfer(1, 1, 32'h7000_0004, 40, 37, -1, 0, -1);
    run_xfer(0, 0, 32'hFFFF_FFF0, 40, 24, -1, 1, -1);
    for (int t = 0; t < 8; t++)
      run_xfer(1'($urandom), ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 40),
               $urandom_range(1, 70), -1, 1, -1);
    chk("busy_out", {31'd0, busyOUT}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
